// File: rtl/rle_run_encoder_if.sv
// Bit-stream in / run-token out handshake bundle for the RLE front end.
// master drives the bit stream and accepts tokens; slave is the encoder side.
interface rle_run_encoder_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_bit;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_bit;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_last;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_count, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_count, out_last
  );
endinterface

// File: rtl/rle_run_encoder.sv
// Collapses runs of identical stream bits into (bit, length, last) tokens.
// Runs longer than 2**CNT_WIDTH-1 are split; in_last closes the open run.
module rle_run_encoder #(
  parameter int CNT_WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  rle_run_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL
  } state_e;

  localparam logic [CNT_WIDTH-1:0] MaxCount = '1;
  localparam logic [CNT_WIDTH-1:0] OneCount = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 curBit_q, curBit_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 pendBit_q, pendBit_d;
  logic                 outValid_q, outValid_d;
  logic                 outBit_q, outBit_d;
  logic [CNT_WIDTH-1:0] outCount_q, outCount_d;
  logic                 outLast_q, outLast_d;

  logic                 free;
  logic                 inReady;
  logic                 accept;
  logic                 emit;
  logic                 emitBit;
  logic [CNT_WIDTH-1:0] emitCount;
  logic                 emitLast;

  always_comb begin
    free    = !outValid_q || bus.out_ready;
    inReady = !reset && (state_q != TAIL) && free;
    accept  = bus.in_valid && inReady;
  end

  // Run tracking; every emit happens only while the output slot is free,
  // so a held token is never overwritten.
  always_comb begin
    state_d   = state_q;
    curBit_d  = curBit_q;
    count_d   = count_q;
    pendBit_d = pendBit_q;
    emit      = 1'b0;
    emitBit   = 1'b0;
    emitCount = '0;
    emitLast  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          curBit_d = bus.in_bit;
          count_d  = OneCount;
          if (bus.in_last) begin
            emit      = 1'b1;
            emitBit   = bus.in_bit;
            emitCount = OneCount;
            emitLast  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if ((bus.in_bit == curBit_q) && (count_q != MaxCount)) begin
            if (bus.in_last) begin
              emit      = 1'b1;
              emitBit   = curBit_q;
              emitCount = count_q + OneCount;
              emitLast  = 1'b1;
              count_d   = '0;
              state_d   = IDLE;
            end else begin
              count_d = count_q + OneCount;
            end
          end else begin
            emit      = 1'b1;
            emitBit   = curBit_q;
            emitCount = count_q;
            emitLast  = 1'b0;
            if (bus.in_last) begin
              pendBit_d = bus.in_bit;
              count_d   = '0;
              state_d   = TAIL;
            end else begin
              curBit_d = bus.in_bit;
              count_d  = OneCount;
            end
          end
        end
      end
      TAIL: begin
        if (free) begin
          emit      = 1'b1;
          emitBit   = pendBit_q;
          emitCount = OneCount;
          emitLast  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot: a pop and an emit on the same edge chain tokens without a bubble.
  always_comb begin
    outValid_d = outValid_q;
    outBit_d   = outBit_q;
    outCount_d = outCount_q;
    outLast_d  = outLast_q;
    if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end
    if (emit) begin
      outValid_d = 1'b1;
      outBit_d   = emitBit;
      outCount_d = emitCount;
      outLast_d  = emitLast;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      curBit_q   <= 1'b0;
      count_q    <= '0;
      pendBit_q  <= 1'b0;
      outValid_q <= 1'b0;
      outBit_q   <= 1'b0;
      outCount_q <= '0;
      outLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      curBit_q   <= curBit_d;
      count_q    <= count_d;
      pendBit_q  <= pendBit_d;
      outValid_q <= outValid_d;
      outBit_q   <= outBit_d;
      outCount_q <= outCount_d;
      outLast_q  <= outLast_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_bit   = outBit_q;
  assign bus.out_count = outCount_q;
  assign bus.out_last  = outLast_q;

endmodule

// File: tb/tb_rle_run_encoder.sv
// Self-checking bench for rle_run_encoder: a run model pushes expected tokens on
// every accepted bit and a negedge monitor pops and compares them on every pop.
module tb_rle_run_encoder;

  localparam int MaxLen = 255;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  rle_run_encoder_if #(.CNT_WIDTH(8)) bus ();
  rle_run_encoder_if #(.CNT_WIDTH(4)) bus4 ();

  rle_run_encoder #(.CNT_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  rle_run_encoder #(.CNT_WIDTH(4)) dut4 (
    .clock(clock),
    .reset(reset),
    .bus  (bus4)
  );

  always #5 clock = ~clock;

  logic [9:0] expQ[$];
  logic [5:0] got4[$];
  logic       mBit = 1'b0;
  int         mLen = 0;
  int         streamBits = 0;
  int         streamSum = 0;
  int         tokensSeen = 0;
  logic [9:0] lastTok = '0;
  logic       holdActive = 1'b0;
  logic [9:0] heldTok = '0;
  logic       randomReady = 1'b0;

  // Inputs change only at posedge+1, so negedge values describe the next edge.
  always @(negedge clock) begin
    logic [9:0] gotTok;
    logic [9:0] expTok;
    if (reset) begin
      expQ.delete();
      mLen       = 0;
      streamBits = 0;
      streamSum  = 0;
      holdActive = 1'b0;
    end else begin
      gotTok = {bus.out_bit, bus.out_count, bus.out_last};
      if (holdActive) begin
        total++;
        if (gotTok !== heldTok) begin
          bad++;
          $display("[TB] FAIL hold_stable: got %b, required %b", gotTok, heldTok);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_token: got bit=%0b count=%0d last=%0b, required none",
                   bus.out_bit, bus.out_count, bus.out_last);
        end else begin
          expTok = expQ.pop_front();
          if (gotTok !== expTok) begin
            bad++;
            $display("[TB] FAIL token: got bit=%0b count=%0d last=%0b, required bit=%0b count=%0d last=%0b",
                     gotTok[9], gotTok[8:1], gotTok[0], expTok[9], expTok[8:1], expTok[0]);
          end
        end
        tokensSeen++;
        lastTok = gotTok;
        streamSum += int'(bus.out_count);
        if (bus.out_last) begin
          total++;
          if (streamSum != streamBits) begin
            bad++;
            $display("[TB] FAIL conservation: got count sum %0d, required %0d", streamSum, streamBits);
          end
          streamSum  = 0;
          streamBits = 0;
        end
      end
      holdActive = bus.out_valid && !bus.out_ready;
      heldTok    = gotTok;
      if (bus.in_valid && bus.in_ready) begin
        streamBits++;
        if (mLen == 0) begin
          mBit = bus.in_bit;
          mLen = 1;
        end else if (bus.in_bit == mBit && mLen < MaxLen) begin
          mLen++;
        end else begin
          expQ.push_back({mBit, 8'(mLen), 1'b0});
          mBit = bus.in_bit;
          mLen = 1;
        end
        if (bus.in_last) begin
          expQ.push_back({mBit, 8'(mLen), 1'b1});
          mLen = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) got4.delete();
    else if (bus4.out_valid && bus4.out_ready)
      got4.push_back({bus4.out_bit, bus4.out_count, bus4.out_last});
  end

  always @(posedge clock) begin
    #1;
    if (randomReady) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic sendBit(input logic b, input logic l);
    int waitCycles = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_last  = l;
    @(negedge clock);
    while (!bus.in_ready && waitCycles < 200) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", waitCycles);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || bus.out_valid) && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    total++;
    if (expQ.size() != 0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_%s: got %0d pending tokens out_valid=%b, required 0 and 0",
               name, expQ.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({bus.out_valid, bus.out_bit, bus.out_count, bus.out_last} !== 11'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got valid=%b bit=%b count=%0d last=%b, required all 0",
               bus.out_valid, bus.out_bit, bus.out_count, bus.out_last);
    end
    total++;
    if (bus.in_ready !== 1'b0 || bus4.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_in_ready: got %b/%b, required 0/0", bus.in_ready, bus4.in_ready);
    end
    total++;
    if (bus4.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_out_valid4: got %b, required 0", bus4.out_valid);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL post_reset_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic;
    int start = tokensSeen;
    bus.out_ready = 1'b1;
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b0, 1'b1);
    waitDrain("basic");
    total++;
    if (tokensSeen - start != 2 || lastTok !== {1'b0, 8'd2, 1'b1}) begin
      bad++;
      $display("[TB] FAIL basic_tokens: got %0d tokens last=%b, required 2 last=%b",
               tokensSeen - start, lastTok, {1'b0, 8'd2, 1'b1});
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_idle: got in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_single;
    sendBit(1'b0, 1'b1);
    total++;
    if ({bus.out_valid, bus.out_bit, bus.out_count, bus.out_last} !== {1'b1, 1'b0, 8'd1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL single_latency: got valid=%b bit=%b count=%0d last=%b, required 1 0 1 1",
               bus.out_valid, bus.out_bit, bus.out_count, bus.out_last);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_idle: got in_ready=%b, required 1", bus.in_ready);
    end
    waitDrain("single");
  endtask

  task automatic test_tail;
    int lowCycles = 0;
    sendBit(1'b0, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (bus.in_ready) break;
      lowCycles++;
      @(posedge clock);
      #1;
    end
    total++;
    if (lowCycles != 1) begin
      bad++;
      $display("[TB] FAIL tail_stall: got %0d cycles with in_ready=0, required 1", lowCycles);
    end
    waitDrain("tail");
  endtask

  task automatic test_backpressure;
    int start = tokensSeen;
    bus.out_ready = 1'b0;
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL backpressure_hold: got in_ready=%b out_valid=%b, required 0 and 1",
                 bus.in_ready, bus.out_valid);
      end
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    sendBit(1'b1, 1'b1);
    waitDrain("backpressure");
    total++;
    if (tokensSeen - start != 3) begin
      bad++;
      $display("[TB] FAIL backpressure_count: got %0d tokens, required 3", tokensSeen - start);
    end
  endtask

  task automatic test_back_to_back;
    int start = tokensSeen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) sendBit(1'(i % 2), i == 11);
    waitDrain("back_to_back");
    total++;
    if (tokensSeen - start != 12) begin
      bad++;
      $display("[TB] FAIL back_to_back_count: got %0d tokens, required 12", tokensSeen - start);
    end
  endtask

  task automatic test_max_split;
    int start = tokensSeen;
    for (int i = 0; i < 300; i++) sendBit(1'b1, i == 299);
    waitDrain("max_split");
    total++;
    if (tokensSeen - start != 2 || lastTok !== {1'b1, 8'd45, 1'b1}) begin
      bad++;
      $display("[TB] FAIL max_split: got %0d tokens last=%b, required 2 last=%b",
               tokensSeen - start, lastTok, {1'b1, 8'd45, 1'b1});
    end
  endtask

  task automatic test_cnt4;
    int n = 0;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_bit   = 1'b1;
      bus4.in_last  = (i == 19);
      @(negedge clock);
      n = 0;
      while (!bus4.in_ready && n < 50) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock);
      #1;
    end
    bus4.in_valid = 1'b0;
    bus4.in_last  = 1'b0;
    n = 0;
    while (got4.size() < 2 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    total++;
    if (got4.size() != 2) begin
      bad++;
      $display("[TB] FAIL cnt4_count: got %0d tokens, required 2", got4.size());
    end else begin
      total++;
      if (got4[0] !== {1'b1, 4'd15, 1'b0} || got4[1] !== {1'b1, 4'd5, 1'b1}) begin
        bad++;
        $display("[TB] FAIL cnt4_tokens: got %b %b, required %b %b",
                 got4[0], got4[1], {1'b1, 4'd15, 1'b0}, {1'b1, 4'd5, 1'b1});
      end
    end
  endtask

  task automatic test_mid_reset;
    int start;
    bus.out_ready = 1'b1;
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_in_ready: got %b, required 0", bus.in_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_out_valid: got %b, required 0", bus.out_valid);
    end
    start = tokensSeen;
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b1);
    waitDrain("mid_reset");
    total++;
    if (tokensSeen - start != 1 || lastTok !== {1'b1, 8'd2, 1'b1}) begin
      bad++;
      $display("[TB] FAIL mid_reset_token: got %0d tokens last=%b, required 1 last=%b",
               tokensSeen - start, lastTok, {1'b1, 8'd2, 1'b1});
    end
  endtask

  task automatic test_random;
    logic b;
    int   len;
    randomReady = 1'b1;
    for (int s = 0; s < 4; s++) begin
      len = $urandom_range(1, 40);
      b   = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) b = ~b;
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clock);
          #1;
        end
        sendBit(b, i == len - 1);
      end
    end
    randomReady   = 1'b0;
    bus.out_ready = 1'b1;
    waitDrain("random");
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_bit     = 1'b0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_bit    = 1'b0;
    bus4.in_last   = 1'b0;
    bus4.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_single();
    test_tail();
    test_backpressure();
    test_back_to_back();
    test_max_split();
    test_cnt4();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
